// File: rtl/dco_tdc_sample_gen.sv
// dco_tdc_sample_gen: behavioural DCO + TDC front end.
// Maps the loop filter's DCO control word to an oscillator period, advances the
// DCO phase by one reference period per accepted ref_tick, and then serially
// builds the 64-tap thermometer sample word the TDC encoder consumes.
//
// Handshake: ref_tick is a one-cycle request. It is accepted only while the
// block is idle (busy low); a ref_tick seen while busy is dropped and latches
// the sticky overrun flag. samples_valid is a one-cycle strobe that marks the
// cycle in which samples carries a new word. There is no back-pressure.
module dco_tdc_sample_gen #(
  parameter logic [15:0] NOMINAL_PQ4 = 16'd800,
  parameter int          KDCO_SHIFT  = 6,
  parameter logic [15:0] PMIN_Q4     = 16'd64,
  parameter logic [15:0] PMAX_Q4     = 16'd4000,
  parameter logic [19:0] REF_Q4      = 20'd25608
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ref_tick,
  input  logic [15:0] dlf_out,
  input  logic        inv_dir,
  output logic [63:0] samples,
  output logic        samples_valid,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] period_q4
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    WALK   = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] phase;
  logic [23:0] acc;
  logic [15:0] pos;
  logic [5:0]  tap_idx;
  logic [63:0] shift;

  // Period map signals
  logic signed [16:0] diff;
  logic signed [16:0] off;
  logic signed [17:0] p_raw;
  logic [15:0]        p_clamped;

  // Walk datapath signals
  logic [15:0] half;
  logic [15:0] walk_p;
  logic [16:0] walk_nxt;
  logic [3:0]  walk_bits;
  logic [15:0] walk_pos_next;
  logic [63:0] assembled;
  logic [63:0] reversed;

  assign busy = (state != IDLE);

  // Control word -> clamped DCO period in q4 taps (higher code = faster DCO)
  always_comb begin
    diff  = $signed({1'b0, dlf_out}) - 17'sh08000;
    off   = diff >>> KDCO_SHIFT;
    p_raw = $signed({2'b00, NOMINAL_PQ4}) - $signed({off[16], off});
    if (p_raw < $signed({2'b00, PMIN_Q4})) begin
      p_clamped = PMIN_Q4;
    end else if (p_raw > $signed({2'b00, PMAX_Q4})) begin
      p_clamped = PMAX_Q4;
    end else begin
      p_clamped = p_raw[15:0];
    end
  end

  // Four chained taps per cycle; pos stays in [0, period) with one subtraction
  // because a 16-q4 tap step is always smaller than the minimum period
  always_comb begin
    half          = period_q4 >> 1;
    walk_p        = pos;
    walk_nxt      = 17'd0;
    walk_bits     = 4'd0;
    for (int k = 0; k < 4; k++) begin
      walk_bits[k] = (walk_p < half);
      walk_nxt     = {1'b0, walk_p} + 17'd16;
      if (walk_nxt >= {1'b0, period_q4}) begin
        walk_nxt = walk_nxt - {1'b0, period_q4};
      end
      walk_p = walk_nxt[15:0];
    end
    walk_pos_next = walk_p;
  end

  // Final word as it will look once the last four taps land, plus its mirror
  always_comb begin
    assembled = {walk_bits, shift[59:0]};
    reversed  = 64'd0;
    for (int i = 0; i < 64; i++) begin
      reversed[i] = assembled[63-i];
    end
  end

  // Main FSM: accept tick, reduce phase modulo period, then walk 64 taps
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= 16'd0;
      acc           <= 24'd0;
      pos           <= 16'd0;
      tap_idx       <= 6'd0;
      shift         <= 64'd0;
      samples       <= 64'd0;
      samples_valid <= 1'b0;
      overrun       <= 1'b0;
      period_q4     <= NOMINAL_PQ4;
    end else begin
      samples_valid <= 1'b0;
      if (ref_tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (ref_tick) begin
            period_q4 <= p_clamped;
            acc       <= {8'd0, phase} + {4'd0, REF_Q4};
            state     <= REDUCE;
          end
        end
        REDUCE: begin
          if (acc >= {8'd0, period_q4}) begin
            acc <= acc - {8'd0, period_q4};
          end else begin
            phase   <= acc[15:0];
            pos     <= acc[15:0];
            tap_idx <= 6'd0;
            state   <= WALK;
          end
        end
        WALK: begin
          shift[tap_idx +: 4] <= walk_bits;
          pos                 <= walk_pos_next;
          tap_idx             <= tap_idx + 6'd4;
          if (tap_idx == 6'd60) begin
            samples       <= inv_dir ? reversed : assembled;
            samples_valid <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dco_tdc_sample_gen.sv
// Bench for dco_tdc_sample_gen: directed plan followed by randomized ticks.
// Two instances: default gain (a) and KDCO_SHIFT = 0 (b) for clamp coverage.
module tb_dco_tdc_sample_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        tick_a = 1'b0;
  logic        tick_b = 1'b0;
  logic [15:0] dlf_out = 16'h8000;
  logic        inv_dir = 1'b0;

  logic [63:0] samples_a, samples_b;
  logic        samples_valid_a, samples_valid_b;
  logic        busy_a, busy_b;
  logic        overrun_a, overrun_b;
  logic [15:0] period_q4_a, period_q4_b;

  dco_tdc_sample_gen dut_a (
    .clk(clk), .rst(rst), .ref_tick(tick_a), .dlf_out(dlf_out), .inv_dir(inv_dir),
    .samples(samples_a), .samples_valid(samples_valid_a), .busy(busy_a),
    .overrun(overrun_a), .period_q4(period_q4_a)
  );

  dco_tdc_sample_gen #(.KDCO_SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .ref_tick(tick_b), .dlf_out(dlf_out), .inv_dir(inv_dir),
    .samples(samples_b), .samples_valid(samples_valid_b), .busy(busy_b),
    .overrun(overrun_b), .period_q4(period_q4_b)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int phase_a  = 0;   // model DCO phase, q4 taps
  int phase_b  = 0;
  logic [63:0] last_a, last_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding expected word
  always @(negedge clk) begin
    if (samples_valid_a) begin
      if (exp_q_a.size() == 0) check("valid_a_unexpected", samples_valid_a, 1'b0);
      else check("samples_a", samples_a, exp_q_a.pop_front());
    end
    if (samples_valid_b) begin
      if (exp_q_b.size() == 0) check("valid_b_unexpected", samples_valid_b, 1'b0);
      else check("samples_b", samples_b, exp_q_b.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    phase_a = 0;
    phase_b = 0;
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  // Reference model: period from the gain law, new phase by modulo, taps by
  // direct evaluation of the 50% duty square wave at tap i.
  task automatic do_tick(input bit on_b, input logic [15:0] dlf, input bit inv,
                         input int over_at, input bit perturb);
    int sh, off, p, acc, n, np, pos, lat;
    logic [63:0] e;
    bit got;
    sh  = on_b ? 0 : 6;
    off = (int'(dlf) - 32768) >>> sh;
    p   = 800 - off;
    if (p < 64) p = 64;
    if (p > 4000) p = 4000;
    acc = (on_b ? phase_b : phase_a) + 25608;
    n   = acc / p;
    np  = acc % p;
    e   = 64'd0;
    for (int i = 0; i < 64; i++) begin
      pos = (np + 16 * i) % p;
      if (inv) e[63-i] = (pos < p / 2);
      else     e[i]    = (pos < p / 2);
    end
    if (on_b) begin exp_q_b.push_back(e); phase_b = np; end
    else      begin exp_q_a.push_back(e); phase_a = np; end

    dlf_out = dlf;
    inv_dir = inv;
    if (on_b) tick_b = 1'b1; else tick_a = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 3000) begin
      step();
      lat++;
      if (lat == 1) begin tick_a = 1'b0; tick_b = 1'b0; end
      if (perturb && lat == 5) dlf_out = 16'($urandom_range(0, 65535));
      if (over_at > 0 && lat == over_at) begin
        if (on_b) tick_b = 1'b1; else tick_a = 1'b1;
      end
      if (over_at > 0 && lat == over_at + 1) begin tick_a = 1'b0; tick_b = 1'b0; end
      got = on_b ? samples_valid_b : samples_valid_a;
    end
    check(on_b ? "latency_b" : "latency_a", 64'(lat), 64'(n + 18));
    check(on_b ? "period_b" : "period_a", on_b ? period_q4_b : period_q4_a, 16'(p));
    check(on_b ? "busy_b_done" : "busy_a_done", on_b ? busy_b : busy_a, 1'b0);
    if (on_b) last_b = samples_b; else last_a = samples_a;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    rst = 1'b0;
    phase_a = 0;
    phase_b = 0;

    // reset state
    check("rst_samples", samples_a, 64'd0);
    check("rst_valid", samples_valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_overrun", overrun_a, 1'b0);
    check("rst_period", period_q4_a, 16'd800);
    check("rst_period_b", period_q4_b, 16'd800);

    // nominal code, two consecutive ticks
    do_tick(1'b0, 16'h8000, 1'b0, 0, 1'b0);
    check("case1_word", last_a, 64'hFFFC_0000_01FF_FFFF);
    do_tick(1'b0, 16'h8000, 1'b0, 0, 1'b0);
    check("case2_word", last_a, 64'hFFFE_0000_00FF_FFFF);

    // reversed tap order
    do_reset();
    do_tick(1'b0, 16'h8000, 1'b1, 0, 1'b0);
    check("case3_word", last_a, 64'hFFFF_FF80_0000_3FFF);

    // period extremes
    do_reset();
    do_tick(1'b0, 16'hFFFF, 1'b0, 0, 1'b0);
    check("case4_p_fast", period_q4_a, 16'd289);
    do_tick(1'b0, 16'h0000, 1'b0, 0, 1'b0);
    check("case4_p_slow", period_q4_a, 16'd1312);
    do_tick(1'b1, 16'hFFFF, 1'b0, 0, 1'b0);
    check("case4_pmin", period_q4_b, 16'd64);
    check("case4_pmin_word", last_b, 64'h3333_3333_3333_3333);
    do_tick(1'b1, 16'h0000, 1'b0, 0, 1'b0);
    check("case4_pmax", period_q4_b, 16'd4000);

    // tick while busy
    check("ovr_before", overrun_a, 1'b0);
    do_tick(1'b0, 16'h8000, 1'b0, 10, 1'b0);
    check("ovr_set", overrun_a, 1'b1);
    do_tick(1'b0, 16'h8000, 1'b0, 0, 1'b0);
    check("ovr_sticky", overrun_a, 1'b1);

    // reset during the tap walk
    do_reset();
    dlf_out = 16'h8000;
    inv_dir = 1'b0;
    tick_a  = 1'b1;
    step();
    tick_a  = 1'b0;
    repeat (39) step();
    check("walk_busy", busy_a, 1'b1);
    do_reset();
    check("abort_busy", busy_a, 1'b0);
    check("abort_samples", samples_a, 64'd0);
    check("abort_overrun", overrun_a, 1'b0);
    repeat (60) step();
    do_tick(1'b0, 16'h8000, 1'b0, 0, 1'b0);
    check("abort_case1_word", last_a, 64'hFFFC_0000_01FF_FFFF);

    // randomized ticks, gaps of 0..3 cycles (0 = tick in the valid cycle)
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) step();
      do_tick(1'b0, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 0, 1'b1);
    end
    repeat (4) step();
    check("queue_a_empty", 64'(exp_q_a.size()), 64'd0);
    check("queue_b_empty", 64'(exp_q_b.size()), 64'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
